// File: rtl/softmax_exp_sum.sv
// Row accumulator for softmax exp() terms: U1Q15 in, clamped U8Q8 row sum out.
// Optional SOFTMAX_SUM_ROUND_EN selects round-half-up instead of truncation.
module softmax_exp_sum #(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_exp,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [LEN_W-1:0] out_len,
    output logic             out_sat,
    output logic             len_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LONE = LEN_W'(1);

    state_e           state_q;
    logic [23:0]      acc_q;
    logic [23:0]      acc_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             err_d;
    logic [24:0]      add;
    logic [16:0]      conv;
    logic [15:0]      sum_d;
    logic             sat_d;
    logic             accept;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [15:0]      out_sum_q;
    logic [LEN_W-1:0] out_len_q;
    logic             out_sat_q;
    logic             len_err_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_len   = out_len_q;
    assign out_sat   = out_sat_q;
    assign len_err   = len_err_q;

    always_comb begin
        accept = in_valid & in_ready_q;
        add    = {1'b0, (state_q == ACCUM) ? acc_q : 24'h0} + {9'h0, in_exp};
        acc_d  = add[24] ? 24'hFFFFFF : add[23:0];
        len_d  = LONE;
        if (state_q == ACCUM)
            len_d = (len_q == LMAX) ? LMAX : len_q + LONE;
        err_d  = len_err_q | ((state_q == ACCUM) && (len_q == LMAX));
`ifdef SOFTMAX_SUM_ROUND_EN
        conv   = {1'b0, acc_d[22:7]} + {16'h0, acc_d[6]};
`else
        conv   = {1'b0, acc_d[22:7]};
`endif
        // Log stage needs x >= 1.0, so tiny sums clamp without flagging
        sat_d  = acc_d[23] | conv[16];
        sum_d  = sat_d ? 16'hFFFF :
                 (conv[15:0] < 16'h0100) ? 16'h0100 : conv[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_len_q   <= '0;
            out_sat_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q     <= acc_d;
                        len_q     <= len_d;
                        len_err_q <= err_d;
                        if (in_last) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_sum_q   <= sum_d;
                            out_len_q   <= len_d;
                            out_sat_q   <= sat_d;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        len_q       <= '0;
                        len_err_q   <= 1'b0;
                        out_sat_q   <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
